// File: rtl/qmult_mac.sv
// Pipelined sign-magnitude Q(N,Q) multiplier / multiply-accumulate.
// Three register stages (multiply, scale, output/accumulate) under a single valid/ready stall.
module qmult_mac #(
  parameter int N     = 32,
  parameter int Q     = 15,
  parameter int ROUND = 0,
  parameter int G     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic         in_mode,
  input  logic         in_first,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_ovr
);
  localparam int PW = 2*N-2;
  localparam int AW = N+G;
  localparam logic [PW:0]          MAXM_P = {{N{1'b0}}, {(N-1){1'b1}}};
  localparam logic [PW:0]          RND    = (ROUND != 0) ? ({{PW{1'b0}}, 1'b1} << (Q-1)) : '0;
  localparam logic [AW-1:0]        MAXM_A = {{(G+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [AW:0]   SMAX   = {2'b00, {(AW-1){1'b1}}};
  localparam logic signed [AW:0]   SMIN   = -SMAX;

  logic advance;
  logic out_valid_q;
  assign advance  = !(out_valid_q && !out_ready);
  assign in_ready = advance;

  // S1: magnitude product
  logic          v1_q, sgn1_q, mode1_q, first1_q, last1_q;
  logic [PW-1:0] prod1_q, prod1_d;
  assign prod1_d = PW'(in_a[N-2:0]) * PW'(in_b[N-2:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q     <= 1'b0;
      prod1_q  <= '0;
      sgn1_q   <= 1'b0;
      mode1_q  <= 1'b0;
      first1_q <= 1'b0;
      last1_q  <= 1'b0;
    end else if (advance) begin
      v1_q     <= in_valid;
      prod1_q  <= prod1_d;
      sgn1_q   <= in_a[N-1] ^ in_b[N-1];
      mode1_q  <= in_mode;
      first1_q <= in_first;
      last1_q  <= in_last;
    end
  end

  // S2: round, shift, clamp, convert to two's complement
  logic [PW:0]   rnd2_d, shf2_d;
  logic          ovr2_d;
  logic [N-2:0]  mag2_d;
  logic [AW-1:0] ext2_d, val2_d;
  assign rnd2_d = {1'b0, prod1_q} + RND;
  assign shf2_d = rnd2_d >> Q;
  assign ovr2_d = shf2_d > MAXM_P;
  assign mag2_d = ovr2_d ? {(N-1){1'b1}} : shf2_d[N-2:0];
  assign ext2_d = {{(G+1){1'b0}}, mag2_d};
  assign val2_d = sgn1_q ? -ext2_d : ext2_d;

  logic                 v2_q, ovr2_q, mode2_q, first2_q, last2_q;
  logic signed [AW-1:0] val2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_q     <= 1'b0;
      val2_q   <= '0;
      ovr2_q   <= 1'b0;
      mode2_q  <= 1'b0;
      first2_q <= 1'b0;
      last2_q  <= 1'b0;
    end else if (advance) begin
      v2_q     <= v1_q;
      val2_q   <= val2_d;
      ovr2_q   <= ovr2_d;
      mode2_q  <= mode1_q;
      first2_q <= first1_q;
      last2_q  <= last1_q;
    end
  end

  // S3: accumulate with saturation, then back to sign-magnitude
  logic signed [AW-1:0] acc_q, acc_d, base_d;
  logic signed [AW:0]   sum_d;
  logic                 stk_q, stk_d, sat_d;
  logic [AW-1:0]        res_d, rmag_d;
  logic                 rneg_d, clamp_d, emit_d, ovr_d;
  logic [N-1:0]         data_d, out_data_q;
  logic                 out_ovr_q;

  assign base_d  = first2_q ? '0 : acc_q;
  assign sum_d   = {base_d[AW-1], base_d} + {val2_q[AW-1], val2_q};
  assign sat_d   = (sum_d > SMAX) || (sum_d < SMIN);
  assign acc_d   = (sum_d > SMAX) ? SMAX[AW-1:0] :
                   (sum_d < SMIN) ? SMIN[AW-1:0] : sum_d[AW-1:0];
  assign stk_d   = (first2_q ? 1'b0 : stk_q) | ovr2_q | sat_d;
  assign res_d   = mode2_q ? acc_d : val2_q;
  assign rneg_d  = res_d[AW-1];
  assign rmag_d  = rneg_d ? -res_d : res_d;
  assign clamp_d = rmag_d > MAXM_A;
  // Two's complement zero has a clear sign bit, so no negative zero can leave here.
  assign data_d  = clamp_d ? {rneg_d, {(N-1){1'b1}}} : {rneg_d, rmag_d[N-2:0]};
  assign ovr_d   = mode2_q ? (clamp_d | stk_d) : ovr2_q;
  assign emit_d  = v2_q && (!mode2_q || last2_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovr_q   <= 1'b0;
      acc_q       <= '0;
      stk_q       <= 1'b0;
    end else if (advance) begin
      out_valid_q <= emit_d;
      if (emit_d) begin
        out_data_q <= data_d;
        out_ovr_q  <= ovr_d;
      end
      if (v2_q && mode2_q) begin
        acc_q <= acc_d;
        stk_q <= stk_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovr   = out_ovr_q;
endmodule

// File: doc/qmult_mac.md
Name: qmult_mac

Overview:
- Pipelined sign-magnitude fixed-point multiplier / multiply-accumulate for the CNN datapath. It is the parametrised successor to the existing single-cycle Q-format multiplier.
- Adds a valid/ready handshake with back-pressure, selectable rounding, saturation with an overflow flag, and a per-beat accumulate mode for dot products.
- Sits between operand fetch (pixel/weight streams) and activation logic.

Parameters:
- N, 32, total word width. Bit N-1 is the sign; bits N-2:0 are the magnitude.
- Q, 15, number of fractional bits in the magnitude.
- ROUND, 0, 0 = truncate, 1 = round-half-up on magnitude.
- G, 8, accumulator guard bits.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- in_a  in  N  multiplicand, sign-magnitude Q(N,Q).
- in_b  in  N  multiplier, sign-magnitude Q(N,Q).
- in_mode  in  1  0 = plain multiply, 1 = accumulate.
- in_first  in  1  (mode 1) beat starts a new sum.
- in_last  in  1  (mode 1) beat ends the sum and emits a result.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  N  result, sign-magnitude Q(N,Q).
- out_ovr  out  1  saturation occurred for this result.

Behaviour:
- Reset (async, rst=1): all stage valids = 0, out_valid = 0, out_data = 0, out_ovr = 0, accumulator = 0, sticky overflow = 0. in_ready = 1 once rst is released.
- Advance condition: advance = !(out_valid && !out_ready). in_ready = advance, combinational.
  - All stages shift only when advance = 1.
  - A beat is accepted when in_valid && in_ready.
- Stage S1 (multiply):
  - magnitude product = in_a[N-2:0] * in_b[N-2:0], width 2N-2.
  - sign = in_a[N-1] ^ in_b[N-1].
  - mode, first and last are registered alongside the product.
- Stage S2 (scale):
  - ROUND=1: magnitude += 2^(Q-1) before the shift.
  - Shift right by Q.
  - If the shifted value > 2^(N-1)-1: clamp to 2^(N-1)-1 and set the beat's ovr flag.
  - Convert to a signed two's-complement value of width N+G.
- Stage S3 (output / accumulate):
  - Mode 0: out_data = the sign-magnitude form of the S2 value. out_valid = 1 and out_ovr = the beat's ovr flag.
  - Mode 1, accumulator update: if first, acc = value; otherwise acc = acc + value.
  - Mode 1, accumulator saturation: acc saturates at ±(2^(N+G-1)-1). Saturation ORs into the sticky overflow.
  - Mode 1, sticky overflow: a first beat resets it to that beat's ovr flag. Later beats OR their ovr flag into it.
  - Mode 1, non-last beats produce no output; out_valid stays 0 for them.
  - Mode 1, last beat: out_valid = 1. out_data = acc converted to sign-magnitude. If |acc| > 2^(N-1)-1, out_data is clamped to max magnitude with the acc sign and out_ovr = 1; otherwise out_ovr = the sticky overflow.
- Zero result: the sign bit is forced to 0 (no negative zero), in all modes.
- Latency: the result appears exactly 3 clk after acceptance when out_ready is held 1. Throughput is 1 beat per clk.
- Stall: while out_valid && !out_ready, out_data, out_ovr and all pipeline contents hold, and in_ready = 0.
- first && last in the same beat: a one-term sum; output = that product.
- Mode 1 beat without a preceding first: adds to the current acc (no error).
- in_mode changes between beats are allowed. A mode-0 beat does not disturb acc.
- Reset mid-operation: in-flight beats are discarded and the partial sum is lost.

Test Plan (N=32, Q=15):
- Mode 0, a=0x0000C000 (1.5), b=0x00010000 (2.0) -> 3 clk later out_valid=1, out_data=0x00018000, out_ovr=0.
- Mode 0, a=0x8000C000 (-1.5), b=0x00010000 -> out_data=0x80018000. Then a=0x80000000 (-0), b=0x00010000 -> out_data=0x00000000 (sign forced 0).
- Mode 0, a=0x7FFFFFFF, b=0x00010000 -> out_data=0x7FFFFFFF, out_ovr=1.
- Mode 0, a=0x00000001, b=0x00004000:
  - ROUND=0 -> out_data=0x00000000.
  - ROUND=1 -> out_data=0x00000001.
- Mode 1, 4 back-to-back beats of a=0x00008000 (1.0), b=0x00004000 (0.5), first on beat 0, last on beat 3 -> exactly one out_valid pulse, out_data=0x00010000, out_ovr=0.
- Back-pressure, then reset:
  - Stream 6 mode-0 beats, drop out_ready for 4 clk -> in_ready=0 while stalled, out_data held, no beats lost or duplicated, order preserved.
  - Assert rst mid-stream -> out_valid=0 and out_data=0 immediately; the next sum starts clean.
